scratchpad_port_arbiter: RTL and testbench

Arbitrates the single scratchpad memory port between three requesters: array result write-back, host (SPI) data write, and host result read. It sits between the matrix controller/SPI bridge and the scratchpad RAM. A 2-entry skid FIFO absorbs result writes so the systolic array never stalls. A starvation guard prevents the host paths from being locked out.

---
 rtl/scratchpad_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_scratchpad_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_port_arbiter.sv
// Shares the single scratchpad RAM port between result write-back (via a 2-entry skid FIFO),
// host writes and host reads, with a per-host starvation guard.
module scratchpad_port_arbiter #(
  parameter int unsigned ADDR_SIZE    = 10,
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [ADDR_SIZE-1:0] res_addr,
  input  logic [WORD_SIZE-1:0] res_data,
  input  logic                 hw_valid,
  output logic                 hw_ready,
  input  logic [ADDR_SIZE-1:0] hw_addr,
  input  logic [WORD_SIZE-1:0] hw_data,
  input  logic                 hr_valid,
  output logic                 hr_ready,
  input  logic [ADDR_SIZE-1:0] hr_addr,
  output logic                 hr_rvalid,
  output logic [WORD_SIZE-1:0] hr_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {GntNone, GntFifo, GntHw, GntHr} gnt_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] fifo_addr_q [2];
  logic [WORD_SIZE-1:0] fifo_data_q [2];
  logic [3:0]           hw_cnt_q, hw_cnt_d, hr_cnt_q, hr_cnt_d;
  logic                 last_host_q, last_host_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  gnt_e gnt;
  logic fifo_room, hw_force, hr_force, push, pop;

  // A full FIFO always wins so the array never stalls; otherwise a starving host goes first.
  always_comb begin
    fifo_room = (count_q != 2'd2);
    hw_force  = hw_valid & (hw_cnt_q == StarveMax);
    hr_force  = hr_valid & (hr_cnt_q == StarveMax);
    gnt       = GntNone;
    if (reset) begin
      gnt = GntNone;
    end else if ((hw_force | hr_force) & fifo_room) begin
      if (hw_force & hr_force) gnt = last_host_q ? GntHw : GntHr;
      else if (hw_force)       gnt = GntHw;
      else                     gnt = GntHr;
    end else if (count_q != 2'd0) begin
      gnt = GntFifo;
    end else if (hw_valid & hr_valid) begin
      gnt = last_host_q ? GntHw : GntHr;
    end else if (hw_valid) begin
      gnt = GntHw;
    end else if (hr_valid) begin
      gnt = GntHr;
    end
  end

  always_comb begin
    res_ready = ~reset & fifo_room;
    hw_ready  = (gnt == GntHw);
    hr_ready  = (gnt == GntHr);
    push      = res_valid & res_ready;
    pop       = (gnt == GntFifo);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt)
      GntFifo: begin
        mem_we    = 1'b1;
        mem_addr  = fifo_addr_q[rd_ptr_q];
        mem_wdata = fifo_data_q[rd_ptr_q];
      end
      GntHw: begin
        mem_we    = 1'b1;
        mem_addr  = hw_addr;
        mem_wdata = hw_data;
      end
      GntHr: begin
        mem_re   = 1'b1;
        mem_addr = hr_addr;
      end
      GntNone: ;
    endcase
  end

  // Read data bypasses straight from the RAM in the return cycle, then is held.
  always_comb begin
    rdata_d   = rd_pend_q ? mem_rdata : rdata_q;
    hr_rvalid = ~reset & rd_pend_q;
    hr_rdata  = reset ? '0 : rdata_d;
    busy      = ~reset & ((count_q != 2'd0) | rd_pend_q);
  end

  always_comb begin
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;

    if (!hw_valid || hw_ready)   hw_cnt_d = '0;
    else if (hw_cnt_q < StarveMax) hw_cnt_d = hw_cnt_q + 4'd1;
    else                         hw_cnt_d = hw_cnt_q;

    if (!hr_valid || hr_ready)   hr_cnt_d = '0;
    else if (hr_cnt_q < StarveMax) hr_cnt_d = hr_cnt_q + 4'd1;
    else                         hr_cnt_d = hr_cnt_q;

    last_host_d = last_host_q;
    if (gnt == GntHw) last_host_d = 1'b0;
    if (gnt == GntHr) last_host_d = 1'b1;

    rd_pend_d = (gnt == GntHr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      hw_cnt_q    <= '0;
      hr_cnt_q    <= '0;
      last_host_q <= 1'b1;
      rd_pend_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      hw_cnt_q    <= hw_cnt_d;
      hr_cnt_q    <= hr_cnt_d;
      last_host_q <= last_host_d;
      rd_pend_q   <= rd_pend_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= res_addr;
      fifo_data_q[wr_ptr_q] <= res_data;
    end
  end

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Randomized bench: a queue/array reference model predicts every cycle's port activity and read
// data; a negedge monitor compares the DUT against the predictions.
module tb_scratchpad_port_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  logic          clk, reset;
  logic          res_valid, res_ready, hw_valid, hw_ready, hr_valid, hr_ready;
  logic [AW-1:0] res_addr, hw_addr, hr_addr, mem_addr;
  logic [DW-1:0] res_data, hw_data, hr_rdata, mem_wdata, mem_rdata;
  logic          hr_rvalid, mem_we, mem_re, busy;

  scratchpad_port_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
    .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_addr(hw_addr), .hw_data(hw_data),
    .hr_valid(hr_valid), .hr_ready(hr_ready), .hr_addr(hr_addr),
    .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad RAM environment with one-cycle read latency.
  logic          ram_clear;
  logic [DW-1:0] ram [1024];

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 37 + 'h5A5);
  endfunction

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    bit            rr, hwr, hrr, we, re, rv, bsy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  exp_t eq[$];
  int   n_cmp, n_bad;

  // Reference model state
  ent_t          mq[$];
  int            hw_c, hr_c;
  bit            m_last, m_pend;
  logic [DW-1:0] m_rd, m_hold;
  logic [DW-1:0] shadow [1024];

  // Outstanding stimulus, held until the model says it was taken
  bit            res_p, hw_p, hr_p;
  logic [AW-1:0] res_a, hw_a, hr_a;
  logic [DW-1:0] res_d, hw_d;
  int            pr_res, pr_hw, pr_hr;
  int            cyc;

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(3) == 0) return AW'($urandom);
    return AW'($urandom_range(31));
  endfunction

  task automatic model_reset();
    mq.delete();
    hw_c   = 0;
    hr_c   = 0;
    m_last = 1'b1;
    m_pend = 1'b0;
    m_hold = '0;
  endtask

  task automatic step(input bit rst);
    exp_t e;
    int   cnt, g;
    bit   hws, hrs, hw_v, hr_v;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      if (!res_p && $urandom_range(99) < pr_res) begin
        res_p = 1; res_a = rand_addr(); res_d = DW'($urandom);
      end
      if (!hw_p && $urandom_range(99) < pr_hw) begin
        hw_p = 1; hw_a = rand_addr(); hw_d = DW'($urandom);
      end
      if (!hr_p && $urandom_range(99) < pr_hr) begin
        hr_p = 1; hr_a = rand_addr();
      end
    end
    reset     = rst;
    res_valid = rst ? 1'b1 : res_p;
    hw_valid  = rst ? 1'b1 : hw_p;
    hr_valid  = rst ? 1'b1 : hr_p;
    res_addr  = rst ? rand_addr() : res_a;
    res_data  = rst ? DW'($urandom) : res_d;
    hw_addr   = rst ? rand_addr() : hw_a;
    hw_data   = rst ? DW'($urandom) : hw_d;
    hr_addr   = rst ? rand_addr() : hr_a;

    e = '{default: '0};
    if (rst) begin
      eq.push_back(e);
      model_reset();
      return;
    end

    cnt  = mq.size();
    hw_v = hw_p;
    hr_v = hr_p;
    hws  = hw_v && hw_c == LIMIT;
    hrs  = hr_v && hr_c == LIMIT;
    // g: 0 none, 1 FIFO, 2 host write, 3 host read
    if ((hws || hrs) && cnt < 2) g = (hws && hrs) ? (m_last ? 2 : 3) : (hws ? 2 : 3);
    else if (cnt > 0)            g = 1;
    else if (hw_v && hr_v)       g = m_last ? 2 : 3;
    else if (hw_v)               g = 2;
    else if (hr_v)               g = 3;
    else                         g = 0;

    e.rr  = cnt < 2;
    e.hwr = g == 2;
    e.hrr = g == 3;
    e.we  = g == 1 || g == 2;
    e.re  = g == 3;
    e.rv  = m_pend;
    e.rd  = m_pend ? m_rd : m_hold;
    e.bsy = cnt != 0 || m_pend;
    if (g == 1) begin e.addr = mq[0].a; e.wd = mq[0].d; end
    if (g == 2) begin e.addr = hw_a;    e.wd = hw_d;    end
    if (g == 3) e.addr = hr_a;
    eq.push_back(e);

    if (m_pend) m_hold = m_rd;
    m_pend = (g == 3);
    if (g == 3) begin m_rd = shadow[hr_a]; hr_p = 0; m_last = 1'b1; end
    if (g == 2) begin shadow[hw_a] = hw_d; hw_p = 0; m_last = 1'b0; end
    if (g == 1) begin shadow[mq[0].a] = mq[0].d; void'(mq.pop_front()); end
    if (res_p && cnt < 2) begin mq.push_back({res_a, res_d}); res_p = 0; end
    hw_c = (!hw_v || g == 2) ? 0 : (hw_c < LIMIT ? hw_c + 1 : hw_c);
    hr_c = (!hr_v || g == 3) ? 0 : (hr_c < LIMIT ? hr_c + 1 : hr_c);
  endtask

  // Monitor
  initial begin
    exp_t                e;
    logic [6:0]          got_c, exp_c;
    logic [AW+DW-1:0]    got_m, exp_m;
    forever begin
      @(negedge clk);
      if (eq.size() > 0) begin
        e     = eq.pop_front();
        got_c = {res_ready, hw_ready, hr_ready, mem_we, mem_re, hr_rvalid, busy};
        exp_c = {e.rr, e.hwr, e.hrr, e.we, e.re, e.rv, e.bsy};
        n_cmp++;
        if (got_c !== exp_c) begin
          n_bad++;
          $display("FAIL ctl cycle %0d: got rr/hw/hr/we/re/rv/busy=%b required %b", cyc, got_c,
                   exp_c);
        end
        got_m = {mem_addr, e.re ? DW'(0) : mem_wdata};
        exp_m = {e.addr, e.re ? DW'(0) : e.wd};
        n_cmp++;
        if (got_m !== exp_m) begin
          n_bad++;
          $display("FAIL mem cycle %0d: got addr/wdata=%h required %h", cyc, got_m, exp_m);
        end
        n_cmp++;
        if (hr_rdata !== e.rd) begin
          n_bad++;
          $display("FAIL rdata cycle %0d: got %h required %h", cyc, hr_rdata, e.rd);
        end
      end
    end
  end

  initial begin
    int ph [6][4] = '{'{30, 30, 30, 400}, '{100, 40, 0, 200}, '{100, 0, 100, 200},
                      '{0, 100, 100, 200}, '{100, 100, 100, 300}, '{60, 20, 60, 400}};
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    res_p = 0; hw_p = 0; hr_p = 0;
    res_a = '0; hw_a = '0; hr_a = '0; res_d = '0; hw_d = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    model_reset();
    reset = 1'b1; ram_clear = 1'b1;
    res_valid = 0; hw_valid = 0; hr_valid = 0;
    res_addr = '0; res_data = '0; hw_addr = '0; hw_data = '0; hr_addr = '0;
    @(posedge clk);
    #1 ram_clear = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1);

    // First post-reset cycle: lone host write
    pr_res = 0; pr_hw = 0; pr_hr = 0;
    hw_p = 1; hw_a = AW'('h010); hw_d = DW'('hBEEF);
    step(1'b0);

    for (int p = 0; p < 6; p++) begin
      pr_res = ph[p][0]; pr_hw = ph[p][1]; pr_hr = ph[p][2];
      for (int c = 0; c < ph[p][3]; c++) step(1'b0);
      step(1'b1);
      step(1'b1);
    end
    pr_res = 0; pr_hw = 0; pr_hr = 0;
    for (int c = 0; c < 10; c++) step(1'b0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (eq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked cycles required 0", eq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
